// File: rtl/calc_pkg.sv
// Shared constants for the calculator display controller: FSM encoding, segment
// patterns and slot geometry.
package calc_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam int unsigned NDIG = 4;

  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [6:0] SEG_NEG = 7'b011_1111;
  localparam logic [6:0] SEG_OFF = 7'b111_1111;

endpackage

// File: rtl/calc_display_ctrl_if.sv
// Result-load handshake plus the anode/cathode pin bus of the display controller.
interface calc_display_ctrl_if #(
  parameter int unsigned WIDTH = 11
);

  logic [WIDTH-1:0] value;
  logic             load;
  logic             busy;
  logic [3:0]       anode;
  logic [6:0]       seven_seg;

  modport master (output value, load, input busy, anode, seven_seg);
  modport slave  (input value, load, output busy, anode, seven_seg);

endinterface

// File: rtl/display.sv
// Seven-segment digit decoder, active-low {g,f,e,d,c,b,a}; non-decimal codes blank.
module display
  import calc_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      4'd0:    seg_o = 7'b100_0000;
      4'd1:    seg_o = 7'b111_1001;
      4'd2:    seg_o = 7'b010_0100;
      4'd3:    seg_o = 7'b011_0000;
      4'd4:    seg_o = 7'b001_1001;
      4'd5:    seg_o = 7'b001_0010;
      4'd6:    seg_o = 7'b000_0010;
      4'd7:    seg_o = 7'b111_1000;
      4'd8:    seg_o = 7'b000_0000;
      4'd9:    seg_o = 7'b001_0000;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/calc_display_ctrl.sv
// Signed result to 4-digit multiplexed seven-segment display: double-dabble BCD
// conversion, leading-zero blanking, minus placement and continuous digit scan.
module calc_display_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               rst,
  calc_display_ctrl_if.slave bus
);

  localparam int unsigned     RefW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);

  logic [1:0]            state_q, state_d;
  logic                  sign_q, sign_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [15:0]           bcd_q, bcd_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [NDIG-1:0][3:0]  code_q, code_d;
  logic [NDIG-1:0]       neg_q, neg_d;
  logic [RefW-1:0]       ref_q, ref_d;
  logic [1:0]            idx_q, idx_d;
  logic [3:0]            anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic [6:0]            dec_seg;
  logic [15:0]           bcd_adj;
  logic [1:0]            msd;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    // Slot 0 is never blanked, so msd stays 0 for an all-zero result.
    msd = 2'd0;
    for (int i = 1; i < NDIG; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) msd = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          sign_d  = bus.value[WIDTH-1];
          mag_d   = bus.value[WIDTH-1] ? (~bus.value + 1'b1) : bus.value;
          bcd_d   = '0;
          cnt_d   = 4'(WIDTH);
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {bcd_adj[14:0], mag_q[WIDTH-1]};
        mag_d = mag_q << 1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = COMMIT;
      end
      COMMIT: begin
        for (int i = 0; i < NDIG; i++) begin
          code_d[i] = (i > int'(msd)) ? BLANK : bcd_q[i*4 +: 4];
          neg_d[i]  = 1'b0;
        end
        if (sign_q) begin
          // A non-zero thousands digit cannot fit beside a minus: show overflow.
          if (bcd_q[15:12] != 4'd0) neg_d = '1;
          else                      neg_d[msd + 2'd1] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  display u_display (
    .code_i (code_q[idx_q]),
    .seg_o  (dec_seg)
  );

  always_comb begin
    ref_d   = (ref_q == RefLast) ? '0 : ref_q + 1'b1;
    idx_d   = (ref_q == RefLast) ? idx_q + 2'd1 : idx_q;
    anode_d = ~(4'b0001 << idx_q);
    seg_d   = neg_q[idx_q] ? SEG_NEG : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      code_q  <= {NDIG{BLANK}};
      neg_q   <= '0;
      ref_q   <= '0;
      idx_q   <= '0;
      anode_q <= 4'b1111;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      neg_q   <= neg_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.anode     = anode_q;
  assign bus.seven_seg = seg_q;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Bench for calc_display_ctrl: fixed vector table, random values against a
// decimal-arithmetic display model, and busy/ignore/reset corner sequences.
module tb_calc_display_ctrl;

  localparam int unsigned W    = 11;
  localparam int unsigned RDIV = 4;
  localparam int          BUSY_CYCLES = W + 1;

  localparam logic [6:0] S_OFF = 7'b111_1111;
  localparam logic [6:0] S_NEG = 7'b011_1111;

  typedef struct {
    int              value;
    logic [3:0][6:0] exp;
    string           name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [6:0] seg_tab [10];

  calc_display_ctrl_if #(.WIDTH(W)) bus ();

  calc_display_ctrl #(
    .WIDTH       (W),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Expected slot patterns from decimal arithmetic on the signed value.
  function automatic logic [3:0][6:0] model(input int v);
    logic [3:0][6:0] r;
    int mag;
    int nd;
    int t;
    mag = (v < 0) ? -v : v;
    r   = {4{S_OFF}};
    if (v < 0 && mag >= 1000) return {4{S_NEG}};
    nd = 1;
    t  = mag / 10;
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    t = mag;
    for (int i = 0; i < nd; i++) begin
      r[i] = seg_tab[t % 10];
      t    = t / 10;
    end
    if (v < 0) r[nd] = S_NEG;
    return r;
  endfunction

  task automatic check_display(input string name, input logic [3:0][6:0] exp);
    logic [3:0][6:0] got;
    int onehot_bad;
    got        = '0;
    onehot_bad = 0;
    for (int c = 0; c < 4 * RDIV; c++) begin
      @(negedge clk);
      case (bus.anode)
        4'b1110: got[0] = bus.seven_seg;
        4'b1101: got[1] = bus.seven_seg;
        4'b1011: got[2] = bus.seven_seg;
        4'b0111: got[3] = bus.seven_seg;
        default: onehot_bad++;
      endcase
    end
    chk({name, " anode_onehot_violations"}, onehot_bad, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s slot%0d", name, i), got[i], exp[i]);
    end
  endtask

  task automatic run_conv(input int v, input logic [3:0][6:0] exp, input string name);
    int n;
    logic [31:0] vv;
    vv = v;
    @(negedge clk);
    bus.value = vv[W-1:0];
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, n, BUSY_CYCLES);
    repeat (2) @(negedge clk);
    check_display(name, exp);
  endtask

  initial begin
    vec_t vecs [8];
    int   n;
    int   v;

    seg_tab = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001,
                7'b001_0010, 7'b000_0010, 7'b111_1000, 7'b000_0000, 7'b001_0000};

    vecs[0] = '{1023,  {7'b111_1001, 7'b100_0000, 7'b010_0100, 7'b011_0000}, "v1023"};
    vecs[1] = '{-5,    {S_OFF, S_OFF, S_NEG, 7'b001_0010}, "vm5"};
    vecs[2] = '{0,     {S_OFF, S_OFF, S_OFF, 7'b100_0000}, "v0"};
    vecs[3] = '{-999,  {S_NEG, 7'b001_0000, 7'b001_0000, 7'b001_0000}, "vm999"};
    vecs[4] = '{-1000, {S_NEG, S_NEG, S_NEG, S_NEG}, "vm1000"};
    vecs[5] = '{-1024, {S_NEG, S_NEG, S_NEG, S_NEG}, "vm1024"};
    vecs[6] = '{450,   {S_OFF, 7'b001_1001, 7'b001_0010, 7'b100_0000}, "v450"};
    vecs[7] = '{-42,   {S_OFF, S_NEG, 7'b001_1001, 7'b010_0100}, "vm42"};

    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    repeat (2) @(negedge clk);
    chk("reset anode", bus.anode, 4'b1111);
    chk("reset seg", bus.seven_seg, S_OFF);
    chk("reset busy", bus.busy, 1'b0);

    rst = 1'b0;
    @(negedge clk);
    chk("scan0 anode", bus.anode, 4'b1110);
    chk("scan0 seg", bus.seven_seg, S_OFF);
    repeat (RDIV) @(negedge clk);
    chk("scan1 anode", bus.anode, 4'b1101);
    chk("scan1 seg", bus.seven_seg, S_OFF);
    repeat (RDIV) @(negedge clk);
    chk("scan2 anode", bus.anode, 4'b1011);
    chk("scan2 seg", bus.seven_seg, S_OFF);
    repeat (RDIV) @(negedge clk);
    chk("scan3 anode", bus.anode, 4'b0111);
    chk("scan3 seg", bus.seven_seg, S_OFF);

    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].value, vecs[i].exp, vecs[i].name);
    end

    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 2047)) - 1024;
      run_conv(v, model(v), $sformatf("rand%0d(%0d)", i, v));
    end

    // Second load mid-conversion and a load during COMMIT must both be dropped.
    @(negedge clk);
    bus.value = 11'd1023;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      bus.load = (n == 3) || (n == BUSY_CYCLES);
      if (bus.load) bus.value = 11'd77;
      @(negedge clk);
    end
    bus.load = 1'b0;
    chk("ignore busy_cycles", n, BUSY_CYCLES);
    @(negedge clk);
    chk("ignore commit_load busy", bus.busy, 1'b0);
    @(negedge clk);
    check_display("ignore", model(1023));

    // Reset during conversion aborts it and blanks every slot.
    @(negedge clk);
    bus.value = 11'd321;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst pre busy", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst anode", bus.anode, 4'b1111);
    chk("midrst seg", bus.seven_seg, S_OFF);
    rst = 1'b0;
    check_display("midrst blank", {4{S_OFF}});
    run_conv(-5, model(-5), "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
